// File: rtl/elink_pkg.sv
// Shared types and defaults for the FPGA-side GBT e-link endpoint.
// Optional feature macro used by elink_modport: ELINK_LOOPBACK_EN.
package elink_pkg;

    typedef logic [9:0] elink_word_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        LOCKING  = 2'b01,
        LOCKED   = 2'b10
    } lock_state_t;

    localparam logic [7:0]  DEF_LOCK_COUNT = 8'd16;
    localparam logic [7:0]  DEF_TIMEOUT    = 8'd8;
    localparam elink_word_t DEF_IDLE_WORD  = 10'h000;

    // Saturating 8-bit increment: counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/elink_lock_det.sv
// dclk[0] activity detector: transition detect, idle/lock counters and the
// UNLOCKED -> LOCKING -> LOCKED state machine. o_locked is a register.
module elink_lock_det
    import elink_pkg::*;
#(
    parameter logic [7:0] LOCK_COUNT = DEF_LOCK_COUNT,
    parameter logic [7:0] TIMEOUT    = DEF_TIMEOUT
) (
    input  logic sClk,
    input  logic rst_n,
    input  logic i_dclk0,
    output logic o_locked
);

    logic        r_d0;
    logic        r_primed;
    logic [7:0]  r_idle;
    logic [7:0]  r_lock_cnt;
    logic        r_locked;
    lock_state_t r_state;

    logic        w_trans;
    logic [7:0]  w_idle_next;
    logic [7:0]  w_cnt_next;
    logic        w_timeout;

    // The first sample after reset only primes r_d0, so it can never look like an edge.
    assign w_trans     = r_primed & (r_d0 ^ i_dclk0);
    assign w_idle_next = sat_inc8(r_idle);
    assign w_cnt_next  = sat_inc8(r_lock_cnt);
    // A transition in the expiry cycle wins, so timeout only fires on a quiet cycle.
    assign w_timeout   = ~w_trans & (w_idle_next >= TIMEOUT);

    // Sample dclk[0] once per cycle and remember that the sampler holds a real value.
    always_ff @(posedge sClk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0     <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_d0     <= i_dclk0;
            r_primed <= 1'b1;
        end
    end

    // Idle counter: cycles since the last transition, saturating.
    always_ff @(posedge sClk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= 8'd0;
        end else if (w_trans) begin
            r_idle <= 8'd0;
        end else begin
            r_idle <= w_idle_next;
        end
    end

    // Lock FSM with its transition counter and registered locked flag.
    always_ff @(posedge sClk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= UNLOCKED;
            r_lock_cnt <= 8'd0;
            r_locked   <= 1'b0;
        end else begin
            case (r_state)
                UNLOCKED: begin
                    if (w_trans && (LOCK_COUNT <= 8'd1)) begin
                        r_state    <= LOCKED;
                        r_lock_cnt <= 8'd1;
                        r_locked   <= 1'b1;
                    end else if (w_trans) begin
                        r_state    <= LOCKING;
                        r_lock_cnt <= 8'd1;
                        r_locked   <= 1'b0;
                    end else begin
                        r_state    <= UNLOCKED;
                        r_lock_cnt <= 8'd0;
                        r_locked   <= 1'b0;
                    end
                end
                LOCKING: begin
                    if (w_trans && (w_cnt_next >= LOCK_COUNT)) begin
                        r_state    <= LOCKED;
                        r_lock_cnt <= w_cnt_next;
                        r_locked   <= 1'b1;
                    end else if (w_trans) begin
                        r_state    <= LOCKING;
                        r_lock_cnt <= w_cnt_next;
                        r_locked   <= 1'b0;
                    end else if (w_timeout) begin
                        r_state    <= UNLOCKED;
                        r_lock_cnt <= 8'd0;
                        r_locked   <= 1'b0;
                    end else begin
                        r_state    <= LOCKING;
                        r_lock_cnt <= r_lock_cnt;
                        r_locked   <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (w_timeout) begin
                        r_state    <= UNLOCKED;
                        r_lock_cnt <= 8'd0;
                        r_locked   <= 1'b0;
                    end else begin
                        r_state    <= LOCKED;
                        r_lock_cnt <= r_lock_cnt;
                        r_locked   <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= UNLOCKED;
                    r_lock_cnt <= 8'd0;
                    r_locked   <= 1'b0;
                end
            endcase
        end
    end

    assign o_locked = r_locked;

endmodule

// File: rtl/elink_modport.sv
// FPGA-side endpoint of one 10-bit GBT e-link ("fpga" view of the e-link).
// Registered downlink capture, registered uplink with idle-word insertion.
// Optional feature macro: ELINK_LOOPBACK_EN adds a loopback input that echoes
// captured downlink words onto din and blocks user uplink traffic.
module elink_modport
    import elink_pkg::*;
#(
    parameter logic [7:0] LOCK_COUNT = DEF_LOCK_COUNT,
    parameter logic [7:0] TIMEOUT    = DEF_TIMEOUT,
    parameter logic [9:0] IDLE_WORD  = DEF_IDLE_WORD
) (
    input  logic       sClk,
    input  logic       rst_n,
    input  logic [1:0] dclk,
    input  logic [9:0] dout,
    input  logic       tx_valid,
    output logic [9:0] din,
    output logic       rx_valid,
    output logic       rxrdy,
    output logic       txrdy,
    output logic [9:0] down_data,
    output logic       down_valid,
    input  logic [9:0] up_data,
    input  logic       up_valid,
    output logic       up_ready,
    output logic       locked
`ifdef ELINK_LOOPBACK_EN
    ,
    input  logic       loopback
`endif
);

    logic       w_locked;
    logic       w_lb;
    logic       w_capture;
    logic       w_accept;
    logic       w_loop_word;
    logic       w_dclk1_unused;

    logic [9:0] r_down_data;
    logic       r_down_valid;
    logic [9:0] r_din;
    logic       r_rx_valid;

    // dclk[1] carries no information for this endpoint.
    assign w_dclk1_unused = dclk[1];

    elink_lock_det #(
        .LOCK_COUNT (LOCK_COUNT),
        .TIMEOUT    (TIMEOUT)
    ) u_lock_det (
        .sClk     (sClk),
        .rst_n    (rst_n),
        .i_dclk0  (dclk[0]),
        .o_locked (w_locked)
    );

`ifdef ELINK_LOOPBACK_EN
    assign w_lb = loopback;
`else
    assign w_lb = 1'b0;
`endif

    // All capture/accept decisions use the registered lock flag, so the cycle
    // it drops nothing new enters either path.
    assign w_capture   = w_locked & tx_valid;
    assign up_ready    = w_locked & ~w_lb;
    assign w_accept    = up_valid & up_ready;
    assign w_loop_word = w_lb & w_capture;

    // Downlink capture: one-cycle strobe, data holds between captures.
    always_ff @(posedge sClk or negedge rst_n) begin
        if (!rst_n) begin
            r_down_data  <= 10'h000;
            r_down_valid <= 1'b0;
        end else if (w_capture) begin
            r_down_data  <= dout;
            r_down_valid <= 1'b1;
        end else begin
            r_down_data  <= r_down_data;
            r_down_valid <= 1'b0;
        end
    end

    // Uplink register: loopback echo, accepted user word, or the idle word.
    always_ff @(posedge sClk or negedge rst_n) begin
        if (!rst_n) begin
            r_din      <= IDLE_WORD;
            r_rx_valid <= 1'b0;
        end else if (w_loop_word) begin
            r_din      <= dout;
            r_rx_valid <= 1'b1;
        end else if (w_accept) begin
            r_din      <= up_data;
            r_rx_valid <= 1'b1;
        end else begin
            r_din      <= IDLE_WORD;
            r_rx_valid <= 1'b0;
        end
    end

    assign down_data  = r_down_data;
    assign down_valid = r_down_valid;
    assign din        = r_din;
    assign rx_valid   = r_rx_valid;
    assign locked     = w_locked;
    assign rxrdy      = w_locked;
    assign txrdy      = w_locked;

endmodule

// File: tb/tb_elink_modport.sv
// Directed self-checking bench for elink_modport (default parameters:
// LOCK_COUNT=16, TIMEOUT=8, IDLE_WORD=10'h000). Loopback test is built only
// when ELINK_LOOPBACK_EN is defined.
module tb_elink_modport;

    logic       sClk = 1'b0;
    logic       rst_n;
    logic [1:0] dclk;
    logic [9:0] dout;
    logic       tx_valid;
    logic [9:0] din;
    logic       rx_valid;
    logic       rxrdy;
    logic       txrdy;
    logic [9:0] down_data;
    logic       down_valid;
    logic [9:0] up_data;
    logic       up_valid;
    logic       up_ready;
    logic       locked;
`ifdef ELINK_LOOPBACK_EN
    logic       loopback;
`endif

    int checks   = 0;
    int failures = 0;
    bit keep     = 1'b0;

    elink_modport dut (
        .sClk       (sClk),
        .rst_n      (rst_n),
        .dclk       (dclk),
        .dout       (dout),
        .tx_valid   (tx_valid),
        .din        (din),
        .rx_valid   (rx_valid),
        .rxrdy      (rxrdy),
        .txrdy      (txrdy),
        .down_data  (down_data),
        .down_valid (down_valid),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .locked     (locked)
`ifdef ELINK_LOOPBACK_EN
        ,
        .loopback   (loopback)
`endif
    );

    // Free-running 10 ns system clock.
    always #5 sClk = ~sClk;

    // One clock: optionally toggle dclk[0] first (keeps lock alive), then sample 1 ns after the edge.
    task automatic tick();
        if (keep) dclk[0] = ~dclk[0];
        @(posedge sClk);
        #1;
    endtask

    // Drive 16 transitions (one per cycle) to bring the link into lock.
    task automatic relock();
        keep = 1'b1;
        repeat (16) tick();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL relock: locked=%b want 1", locked);
        end
    endtask

    task automatic test_power_on_reset();
        rst_n = 1'b0; dclk = 2'b01; dout = 10'h000; tx_valid = 1'b0;
        up_data = 10'h000; up_valid = 1'b0;
`ifdef ELINK_LOOPBACK_EN
        loopback = 1'b0;
`endif
        #3;
        checks++;
        if ({din, rx_valid, rxrdy, txrdy, down_data, down_valid, up_ready, locked} !== 26'd0) begin
            failures++;
            $display("FAIL por_async: outs=%h want 0", {din, rx_valid, rxrdy, txrdy, down_data, down_valid, up_ready, locked});
        end
        tick();
        checks++;
        if ({din, rx_valid, rxrdy, txrdy, down_data, down_valid, up_ready, locked} !== 26'd0) begin
            failures++;
            $display("FAIL por_held: outs=%h want 0", {din, rx_valid, rxrdy, txrdy, down_data, down_valid, up_ready, locked});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock_acquire();
        logic exp_l;
        // dclk[0]=1 differs from the reset sampler value; this edge must not count.
        tick();
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL prime_edge: locked=%b want 0", locked);
        end
        for (int k = 1; k <= 16; k++) begin
            dclk[0] = ~dclk[0];
            tick();
            exp_l = (k == 16);
            checks++;
            if ({locked, rxrdy, txrdy, up_ready} !== {4{exp_l}}) begin
                failures++;
                $display("FAIL acquire_t%0d: lock/rxrdy/txrdy/up_ready=%b want %b", k, {locked, rxrdy, txrdy, up_ready}, {4{exp_l}});
            end
            if (k < 16) begin
                tick();
                checks++;
                if (locked !== 1'b0) begin
                    failures++;
                    $display("FAIL acquire_gap%0d: locked=%b want 0", k, locked);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        // 7 quiet cycles then a toggle on the 8th edge: lock kept.
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (locked !== 1'b1) begin
                failures++;
                $display("FAIL idle7_c%0d: locked=%b want 1", i, locked);
            end
        end
        dclk[0] = ~dclk[0];
        tick();
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL idle7_toggle: locked=%b want 1", locked);
        end
        // 8 quiet cycles: lock drops after the 8th.
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if ({locked, rxrdy, txrdy} !== {3{i < 8}}) begin
                failures++;
                $display("FAIL idle8_c%0d: lock/rxrdy/txrdy=%b want %b", i, {locked, rxrdy, txrdy}, {3{i < 8}});
            end
        end
    endtask

    task automatic test_downlink_unlocked();
        dout = 10'h2A5; tx_valid = 1'b1; up_data = 10'h3C3; up_valid = 1'b1;
        tick();
        checks++;
        if ({down_valid, down_data, rx_valid, din} !== {1'b0, 10'h000, 1'b0, 10'h000}) begin
            failures++;
            $display("FAIL unlocked_io: dv/dd/rv/din=%b/%h/%b/%h want 0/000/0/000", down_valid, down_data, rx_valid, din);
        end
        tx_valid = 1'b0; up_valid = 1'b0;
    endtask

    task automatic test_downlink();
        relock();
        dout = 10'h2A5; tx_valid = 1'b1;
        tick();
        checks++;
        if ({down_valid, down_data} !== {1'b1, 10'h2A5}) begin
            failures++;
            $display("FAIL down_capture: dv/dd=%b/%h want 1/2a5", down_valid, down_data);
        end
        tx_valid = 1'b0; dout = 10'h3FF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({down_valid, down_data} !== {1'b0, 10'h2A5}) begin
                failures++;
                $display("FAIL down_hold%0d: dv/dd=%b/%h want 0/2a5", i, down_valid, down_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] w;
        for (int i = 1; i <= 3; i++) begin
            w = 10'(i);
            up_valid = 1'b1; up_data = w;
            tick();
            checks++;
            if ({rx_valid, din} !== {1'b1, w}) begin
                failures++;
                $display("FAIL up_word%0d: rv/din=%b/%h want 1/%h", i, rx_valid, din, w);
            end
        end
        up_valid = 1'b0; up_data = 10'h3FF;
        tick();
        checks++;
        if ({rx_valid, din} !== {1'b0, 10'h000}) begin
            failures++;
            $display("FAIL up_idle: rv/din=%b/%h want 0/000", rx_valid, din);
        end
    endtask

    task automatic test_loss_midstream();
        logic [9:0] wu;
        logic [9:0] wd;
        tick();           // keep is on: fresh transition, idle count restarts
        keep = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wu = 10'h100 + 10'(i); wd = 10'h080 + 10'(i);
            up_valid = 1'b1; up_data = wu; tx_valid = 1'b1; dout = wd;
            tick();
            checks++;
            if ({locked, rx_valid, din, down_valid, down_data} !== {(i < 8), 1'b1, wu, 1'b1, wd}) begin
                failures++;
                $display("FAIL midstream_c%0d: l/rv/din/dv/dd=%b/%b/%h/%b/%h want %b/1/%h/1/%h",
                         i, locked, rx_valid, din, down_valid, down_data, (i < 8), wu, wd);
            end
        end
        up_data = 10'h1FF; dout = 10'h0FF;
        tick();
        checks++;
        if ({locked, rx_valid, din, down_valid, down_data} !== {1'b0, 1'b0, 10'h000, 1'b0, 10'h088}) begin
            failures++;
            $display("FAIL midstream_after: l/rv/din/dv/dd=%b/%b/%h/%b/%h want 0/0/000/0/088",
                     locked, rx_valid, din, down_valid, down_data);
        end
        up_valid = 1'b0; tx_valid = 1'b0;
    endtask

`ifdef ELINK_LOOPBACK_EN
    task automatic test_loopback();
        relock();
        loopback = 1'b1;
        #1;
        checks++;
        if (up_ready !== 1'b0) begin
            failures++;
            $display("FAIL lb_up_ready: up_ready=%b want 0", up_ready);
        end
        dout = 10'h155; tx_valid = 1'b1; up_data = 10'h0AA; up_valid = 1'b1;
        tick();
        checks++;
        if ({down_valid, down_data, rx_valid, din} !== {1'b1, 10'h155, 1'b1, 10'h155}) begin
            failures++;
            $display("FAIL lb_echo: dv/dd/rv/din=%b/%h/%b/%h want 1/155/1/155", down_valid, down_data, rx_valid, din);
        end
        tx_valid = 1'b0;
        tick();
        checks++;
        if ({rx_valid, din} !== {1'b0, 10'h000}) begin
            failures++;
            $display("FAIL lb_no_accept: rv/din=%b/%h want 0/000", rx_valid, din);
        end
        up_valid = 1'b0; loopback = 1'b0;
    endtask
`endif

    task automatic test_reset_midop();
        relock();
        up_valid = 1'b1; up_data = 10'h2F0; tx_valid = 1'b1; dout = 10'h1E1;
        tick();
        checks++;
        if ({locked, rx_valid, din, down_valid, down_data} !== {1'b1, 1'b1, 10'h2F0, 1'b1, 10'h1E1}) begin
            failures++;
            $display("FAIL midop_active: l/rv/din/dv/dd=%b/%b/%h/%b/%h want 1/1/2f0/1/1e1",
                     locked, rx_valid, din, down_valid, down_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({din, rx_valid, rxrdy, txrdy, down_data, down_valid, up_ready, locked} !== 26'd0) begin
            failures++;
            $display("FAIL midop_async_rst: outs=%h want 0", {din, rx_valid, rxrdy, txrdy, down_data, down_valid, up_ready, locked});
        end
        tick();
        checks++;
        if ({din, rx_valid, rxrdy, txrdy, down_data, down_valid, up_ready, locked} !== 26'd0) begin
            failures++;
            $display("FAIL midop_rst_held: outs=%h want 0", {din, rx_valid, rxrdy, txrdy, down_data, down_valid, up_ready, locked});
        end
        keep = 1'b0; up_valid = 1'b0; tx_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    // Scenario sequence and summary.
    initial begin
        test_power_on_reset();
        test_lock_acquire();
        test_lock_loss();
        test_downlink_unlocked();
        test_downlink();
        test_back_to_back();
        test_loss_midstream();
`ifdef ELINK_LOOPBACK_EN
        test_loopback();
`endif
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
